// File: rtl/piece_scanner_if.sv
// Bundle between the piece scanner and its controller, plus the lookup/VGA facing outputs.
// The scanner takes the slave modport and its controller takes the master modport.
interface piece_scanner_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           Start;
  logic           Erase;
  logic [1:0]     Shape;
  logic [X_W-1:0] OriginX;
  logic [Y_W-1:0] OriginY;
  logic           Busy;
  logic           Done;
  logic [1:0]     ShapeOut;
  logic           MSB;
  logic           ColorEnable;
  logic [X_W-1:0] PlotX;
  logic [Y_W-1:0] PlotY;
  logic           Plot;

  modport master (
    output Start, Erase, Shape, OriginX, OriginY,
    input  Busy, Done, ShapeOut, MSB, ColorEnable, PlotX, PlotY, Plot
  );

  modport slave (
    input  Start, Erase, Shape, OriginX, OriginY,
    output Busy, Done, ShapeOut, MSB, ColorEnable, PlotX, PlotY, Plot
  );
endinterface

// File: rtl/piece_scanner.sv
// Walks a 4x4-cell tetromino box one pixel per cycle, feeding the colour lookup stage
// and emitting plot strobes delayed one cycle to line up with the registered colour.
module piece_scanner #(
  parameter int unsigned CELL = 4,
  parameter int unsigned X_W  = 8,
  parameter int unsigned Y_W  = 7
) (
  input  logic             Clock,
  input  logic             Reset,
  piece_scanner_if.slave   bus
);

  localparam int unsigned CntW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CntW-1:0] PxLast = CntW'(CELL - 1);

  typedef enum logic [1:0] {StIdle, StScan, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] px_q, px_d, py_q, py_d;
  logic [1:0]      col_q, col_d, row_q, row_d;
  logic [15:0]     bits_q, bits_d;
  logic [1:0]      shape_q, shape_d;
  logic            erase_q, erase_d;
  logic [X_W-1:0]  ox_q, ox_d, plot_x_q, plot_x_d;
  logic [Y_W-1:0]  oy_q, oy_d, plot_y_q, plot_y_d;
  logic            plot_q, plot_d;
  logic            scan, pix_last, cell_last;
  logic [X_W-1:0]  cur_x;
  logic [Y_W-1:0]  cur_y;

  function automatic logic [15:0] shape_bitmap(input logic [1:0] s);
    case (s)
      2'b00:   return 16'h8E00;
      2'b01:   return 16'h6C00;
      2'b10:   return 16'hCC00;
      default: return 16'hF000;
    endcase
  endfunction

  assign scan      = (state_q == StScan);
  assign pix_last  = (px_q == PxLast) && (py_q == PxLast);
  assign cell_last = pix_last && (col_q == 2'd3) && (row_q == 2'd3);

  // Coordinates wrap naturally at the output widths; no clipping.
  assign cur_x = ox_q + X_W'(32'(col_q) * CELL) + X_W'(px_q);
  assign cur_y = oy_q + Y_W'(32'(row_q) * CELL) + Y_W'(py_q);

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.Start) state_d = StScan;
      StScan:  if (cell_last) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Busy        = (state_q != StIdle);
    bus.Done        = (state_q == StFlush);
    bus.ColorEnable = scan;
    bus.MSB         = scan && bits_q[15] && !erase_q;
    bus.ShapeOut    = shape_q;
    bus.PlotX       = plot_x_q;
    bus.PlotY       = plot_y_q;
    bus.Plot        = plot_q;
  end

  always_comb begin
    px_d     = px_q;
    py_d     = py_q;
    col_d    = col_q;
    row_d    = row_q;
    bits_d   = bits_q;
    shape_d  = shape_q;
    erase_d  = erase_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    plot_d   = scan && bits_q[15];
    plot_x_d = cur_x;
    plot_y_d = cur_y;
    if (state_q == StIdle && bus.Start) begin
      shape_d = bus.Shape;
      erase_d = bus.Erase;
      ox_d    = bus.OriginX;
      oy_d    = bus.OriginY;
      bits_d  = shape_bitmap(bus.Shape);
      px_d    = '0;
      py_d    = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (scan) begin
      if (px_q != PxLast) begin
        px_d = px_q + 1'b1;
      end else begin
        px_d = '0;
        if (py_q != PxLast) begin
          py_d = py_q + 1'b1;
        end else begin
          // Cell finished: advance to next cell; col/row wrap to 0 after the last one.
          py_d   = '0;
          bits_d = {bits_q[14:0], 1'b0};
          col_d  = col_q + 2'd1;
          if (col_q == 2'd3) row_d = row_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      px_q     <= '0;
      py_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      bits_q   <= '0;
      shape_q  <= '0;
      erase_q  <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      plot_q   <= 1'b0;
      plot_x_q <= '0;
      plot_y_q <= '0;
    end else begin
      px_q     <= px_d;
      py_q     <= py_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bits_q   <= bits_d;
      shape_q  <= shape_d;
      erase_q  <= erase_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      plot_q   <= plot_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
    end
  end

endmodule

// File: tb/tb_piece_scanner.sv
// Self-checking bench for piece_scanner: pass-level model compared every cycle, plus
// hand-computed expectations on plot counts, first/last pixels and timing.
module tb_piece_scanner;
  localparam int unsigned C  = 4;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int N = 16 * C * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piece_scanner_if #(.X_W(XW), .Y_W(YW)) bus ();

  piece_scanner #(.CELL(C), .X_W(XW), .Y_W(YW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Model: a pass is "cycle k" (1..N scan, N+1 flush) after acceptance.
  bit        m_active;
  int        m_k;
  int        m_shape;
  bit        m_erase;
  int        m_ox, m_oy;
  bit [15:0] m_bm;
  bit        m_pplot;
  int        m_px, m_py;
  bit        cur_f;
  int        cur_x, cur_y;

  function automatic bit [15:0] bitmap_of(input int s);
    case (s)
      0:       return 16'h8E00;
      1:       return 16'h6C00;
      2:       return 16'hCC00;
      default: return 16'hF000;
    endcase
  endfunction

  always_comb begin
    cur_f = 1'b0;
    cur_x = 0;
    cur_y = 0;
    if (m_active && m_k >= 1 && m_k <= N) begin
      cur_f = m_bm[15 - ((m_k - 1) / (C * C))];
      cur_x = (m_ox + (((m_k - 1) / (C * C)) % 4) * C + (m_k - 1) % C) % (2 ** XW);
      cur_y = (m_oy + (((m_k - 1) / (C * C)) / 4) * C + ((m_k - 1) / C) % C) % (2 ** YW);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_pplot  <= 1'b0;
      m_shape  <= 0;
    end else begin
      m_pplot <= cur_f;
      m_px    <= cur_x;
      m_py    <= cur_y;
      if (!m_active) begin
        if (bus.Start) begin
          m_active <= 1'b1;
          m_k      <= 1;
          m_shape  <= int'(bus.Shape);
          m_erase  <= bus.Erase;
          m_ox     <= int'(bus.OriginX);
          m_oy     <= int'(bus.OriginY);
          m_bm     <= bitmap_of(int'(bus.Shape));
        end
      end else if (m_k == N + 1) begin
        m_active <= 1'b0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc;
  int n_plot, n_msb, n_done, first_cyc, fx, fy, lx, ly, done_cyc, busy_low;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    bit ce;
    ce = m_active && m_k <= N;
    chk("busy", int'(bus.Busy), int'(m_active));
    chk("done", int'(bus.Done), int'(m_active && m_k == N + 1));
    chk("color_enable", int'(bus.ColorEnable), int'(ce));
    chk("msb", int'(bus.MSB), int'(ce && cur_f && !m_erase));
    chk("plot", int'(bus.Plot), int'(m_pplot));
    if (ce) chk("shape_out", int'(bus.ShapeOut), m_shape);
    if (m_pplot) begin
      chk("plot_x", int'(bus.PlotX), m_px);
      chk("plot_y", int'(bus.PlotY), m_py);
    end
    if (bus.Plot) begin
      n_plot++;
      if (first_cyc < 0) begin
        first_cyc = cyc;
        fx = int'(bus.PlotX);
        fy = int'(bus.PlotY);
      end
      lx = int'(bus.PlotX);
      ly = int'(bus.PlotY);
    end
    if (bus.MSB) n_msb++;
    if (bus.Done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!bus.Busy && cyc > 1 && busy_low < 0) busy_low = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic start_pass(input int shape, input bit erase, input int ox, input int oy);
    bus.Start   = 1'b1;
    bus.Shape   = 2'(shape);
    bus.Erase   = erase;
    bus.OriginX = XW'(ox);
    bus.OriginY = YW'(oy);
    cyc = 0; n_plot = 0; n_msb = 0; n_done = 0; first_cyc = -1;
    fx = -1; fy = -1; lx = -1; ly = -1; done_cyc = -1; busy_low = -1;
  endtask

  task automatic run_to(input int last);
    while (cyc < last) begin
      step();
      if (cyc == 1) bus.Start = 1'b0;
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Erase = 1'b0; bus.Shape = 2'd0;
    bus.OriginX = '0; bus.OriginY = '0;
    cyc = 0;
    repeat (3) step();
    chk("reset_busy", int'(bus.Busy), 0);
    chk("reset_plot", int'(bus.Plot), 0);
    chk("reset_color_enable", int'(bus.ColorEnable), 0);
    rst = 1'b0;
    step();

    // I piece at (10,20)
    start_pass(3, 1'b0, 10, 20);
    run_to(N + 3);
    chk("i_plots", n_plot, 64);
    chk("i_msb", n_msb, 64);
    chk("i_first_cycle", first_cyc, 2);
    chk("i_first_x", fx, 10);
    chk("i_first_y", fy, 20);
    chk("i_last_x", lx, 25);
    chk("i_last_y", ly, 23);
    chk("i_done_cycle", done_cyc, 257);
    chk("i_done_count", n_done, 1);
    chk("i_busy_low", busy_low, 258);

    // O piece at (0,0)
    start_pass(2, 1'b0, 0, 0);
    run_to(N + 3);
    chk("o_plots", n_plot, 64);
    chk("o_msb", n_msb, 64);
    chk("o_first_x", fx, 0);
    chk("o_last_x", lx, 7);
    chk("o_last_y", ly, 7);

    // J piece erase at (50,60)
    start_pass(0, 1'b1, 50, 60);
    run_to(N + 3);
    chk("j_erase_msb", n_msb, 0);
    chk("j_erase_plots", n_plot, 64);
    chk("j_first_x", fx, 50);
    chk("j_first_y", fy, 60);
    chk("j_last_x", lx, 61);
    chk("j_last_y", ly, 67);

    // I piece wrapping at (250,125)
    start_pass(3, 1'b0, 250, 125);
    run_to(N + 3);
    chk("wrap_plots", n_plot, 64);
    chk("wrap_first_x", fx, 250);
    chk("wrap_first_y", fy, 125);
    chk("wrap_last_x", lx, 9);
    chk("wrap_last_y", ly, 0);
    chk("wrap_done_cycle", done_cyc, 257);

    // Reset in the middle of a J pass
    start_pass(0, 1'b0, 30, 40);
    run_to(100);
    chk("pre_reset_plot", int'(bus.Plot), 1);
    rst = 1'b1;
    run_to(101);
    rst = 1'b0;
    chk("mid_reset_busy", int'(bus.Busy), 0);
    chk("mid_reset_plot", int'(bus.Plot), 0);
    chk("mid_reset_color_enable", int'(bus.ColorEnable), 0);
    chk("mid_reset_done", int'(bus.Done), 0);
    run_to(104);
    chk("mid_reset_no_done", n_done, 0);

    // Clean S pass after the reset
    start_pass(1, 1'b0, 5, 5);
    run_to(N + 3);
    chk("s_plots", n_plot, 64);
    chk("s_first_x", fx, 9);
    chk("s_first_y", fy, 5);
    chk("s_done_count", n_done, 1);
    chk("s_done_cycle", done_cyc, 257);

    // Second Start during a pass is ignored
    start_pass(3, 1'b0, 10, 20);
    run_to(49);
    bus.Start = 1'b1; bus.Shape = 2'd2; bus.OriginX = 8'd100; bus.OriginY = 7'd50;
    run_to(50);
    bus.Start = 1'b0;
    run_to(N + 3);
    chk("restart_done_count", n_done, 1);
    chk("restart_plots", n_plot, 64);
    chk("restart_last_x", lx, 25);
    chk("restart_last_y", ly, 23);
    chk("restart_done_cycle", done_cyc, 257);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
